// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD text controller.
//   lcd_state_t  - sequencer state encoding
//   CMD_*        - HD44780 command bytes used during configuration and addressing
//   LCD_COLS/LCD_LINES - screen geometry (2 x 16)
//   cfg_cmd()    - configuration command for a given step of the init sequence
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_WAIT,
    CFG_SEND,
    CFG_WAIT,
    CLR_DELAY,
    IDLE,
    ADDR_SEND,
    ADDR_WAIT,
    CHAR_SEND,
    CHAR_WAIT
  } lcd_state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_LINE0    = 8'h80;
  localparam logic [7:0] CMD_LINE1    = 8'hC0;

  localparam int LCD_COLS  = 16;
  localparam int LCD_LINES = 2;

  // Clear-display is deliberately last: it is the only command that needs
  // the long post-command delay.
  function automatic logic [7:0] cfg_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_cmd = CMD_FUNC_SET;
      2'd1:    cfg_cmd = CMD_ENTRY;
      2'd2:    cfg_cmd = CMD_DISP_ON;
      default: cfg_cmd = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/lcd_text_controller.sv
// lcd_text_controller: byte sequencer in front of the LCD physical-layer driver.
// Issues the driver init request after the power-on delay, sends the four
// configuration commands, waits out the clear-display time, then rewrites the
// 2x16 screen (address byte + 16 characters per line) whenever refresh is seen.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous, active-low reset
//   refresh        one-cycle request to rewrite the whole screen
//   char_data      character code for char_addr (combinational from formatter)
//   init_done      one-cycle done pulse from the driver for do_init
//   send_data_done one-cycle done pulse from the driver for do_send_data
//   char_addr      character index {line, col}
//   do_init        one-cycle init request to the driver
//   do_send_data   one-cycle byte request to the driver
//   data_to_send   byte for the driver, held from request until done
//   lcdrs_out      0 = command, 1 = character, held with data_to_send
//   ready          configured, idle and no refresh pending
//
// state     | meaning
// ----------+-----------------------------------------------------------
// PWR_WAIT  | power-on delay, then pulse do_init
// INIT_WAIT | waiting for init_done
// CFG_SEND  | issue configuration command cfg_idx
// CFG_WAIT  | waiting for done of a configuration command
// CLR_DELAY | clear-display execution delay
// IDLE      | ready; start a screen write when a refresh is pending
// ADDR_SEND | issue DDRAM address for the current line
// ADDR_WAIT | waiting for done of the address byte
// CHAR_SEND | capture char_data and issue it
// CHAR_WAIT | waiting for done of a character byte
module lcd_text_controller
  import lcd_pkg::*;
#(
  parameter int POWERON_WAIT = 750000,
  parameter int CLEAR_WAIT   = 100000,
  parameter int CNT_W        = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh,
  input  logic [7:0] char_data,
  input  logic       init_done,
  input  logic       send_data_done,
  output logic [4:0] char_addr,
  output logic       do_init,
  output logic       do_send_data,
  output logic [7:0] data_to_send,
  output logic       lcdrs_out,
  output logic       ready
);

  localparam int                LINE_W    = $clog2(LCD_LINES);
  localparam int                COL_W     = $clog2(LCD_COLS);
  localparam logic [CNT_W-1:0]  PWR_TC    = CNT_W'(POWERON_WAIT - 1);
  localparam logic [CNT_W-1:0]  CLR_TC    = CNT_W'(CLEAR_WAIT - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(LCD_COLS - 1);
  localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LCD_LINES - 1);

  lcd_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        cfg_idx;
  logic [LINE_W-1:0] line;
  logic [COL_W-1:0]  col;
  logic              pending;

  // line/col are flops, so the formatter address is already registered and
  // valid for the whole CHAR_SEND cycle.
  assign char_addr = {line, col};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= PWR_WAIT;
      cnt          <= '0;
      cfg_idx      <= '0;
      line         <= '0;
      col          <= '0;
      pending      <= 1'b0;
      do_init      <= 1'b0;
      do_send_data <= 1'b0;
      data_to_send <= 8'h00;
      lcdrs_out    <= 1'b0;
      ready        <= 1'b0;
    end else begin
      do_init      <= 1'b0;
      do_send_data <= 1'b0;
      ready        <= 1'b0;
      if (refresh) pending <= 1'b1;

      case (state)
        PWR_WAIT: begin
          if (cnt == PWR_TC) begin
            cnt     <= '0;
            do_init <= 1'b1;
            state   <= INIT_WAIT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        INIT_WAIT: begin
          if (init_done) begin
            cfg_idx <= '0;
            state   <= CFG_SEND;
          end
        end
        CFG_SEND: begin
          data_to_send <= cfg_cmd(cfg_idx);
          lcdrs_out    <= 1'b0;
          do_send_data <= 1'b1;
          state        <= CFG_WAIT;
        end
        CFG_WAIT: begin
          if (send_data_done) begin
            if (cfg_idx == 2'd3) begin
              cnt   <= '0;
              state <= CLR_DELAY;
            end else begin
              cfg_idx <= cfg_idx + 2'd1;
              state   <= CFG_SEND;
            end
          end
        end
        CLR_DELAY: begin
          if (cnt == CLR_TC) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          // A refresh arriving this very cycle is folded into the write
          // started here, so the clear below must win over the latch above.
          if (pending || refresh) begin
            pending <= 1'b0;
            line    <= '0;
            state   <= ADDR_SEND;
          end else begin
            ready <= 1'b1;
          end
        end
        ADDR_SEND: begin
          data_to_send <= (line == '0) ? CMD_LINE0 : CMD_LINE1;
          lcdrs_out    <= 1'b0;
          do_send_data <= 1'b1;
          state        <= ADDR_WAIT;
        end
        ADDR_WAIT: begin
          if (send_data_done) begin
            col   <= '0;
            state <= CHAR_SEND;
          end
        end
        CHAR_SEND: begin
          data_to_send <= char_data;
          lcdrs_out    <= 1'b1;
          do_send_data <= 1'b1;
          state        <= CHAR_WAIT;
        end
        CHAR_WAIT: begin
          if (send_data_done) begin
            if (col != COL_LAST) begin
              col   <= col + 1'b1;
              state <= CHAR_SEND;
            end else if (line != LINE_LAST) begin
              line  <= line + 1'b1;
              state <= ADDR_SEND;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: doc/lcd_text_controller.md
# lcd_text_controller

Sequencing stage directly upstream of the LCD physical-layer driver: issues its initialisation request, sends the HD44780 configuration commands, then writes a 2×16 character screen on request. Characters are fetched from the tuner display formatter through a 5-bit address / 8-bit data read port. The physical driver performs all nibble and enable timing; this block sequences bytes and handles the power-on and clear-display delays.

## Interface
Parameters:
- POWERON_WAIT, 750000: cycles after reset release before `do_init` (15 ms at 50 MHz).
- CLEAR_WAIT, 100000: cycles waited after the clear-display command (≥1.64 ms).
- CNT_W, 20: delay-counter width; must hold max(POWERON_WAIT, CLEAR_WAIT).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- refresh  in  1  one-cycle request to rewrite the full screen.
- char_data  in  8  ASCII code for `char_addr`, valid combinationally in the same cycle.
- init_done  in  1  one-cycle done pulse from the physical driver.
- send_data_done  in  1  one-cycle done pulse from the physical driver.
- char_addr  out  5  character index: 0–15 line 0, 16–31 line 1.
- do_init  out  1  one-cycle request to the physical driver.
- do_send_data  out  1  one-cycle request to the physical driver.
- data_to_send  out  8  byte to send; held stable from the request until done.
- lcdrs_out  out  1  0 = command, 1 = character; held with `data_to_send`.
- ready  out  1  high when configuration is complete and no write is active or pending.

## Operation
- All outputs are registered. Reset values: `do_init`=0, `do_send_data`=0, `data_to_send`=0x00, `lcdrs_out`=0, `char_addr`=0, `ready`=0. State on reset is PWR_WAIT with the counter at 0.
- State machine:
  - **PWR_WAIT**: count to POWERON_WAIT-1, then pulse `do_init` → INIT_WAIT.
  - **INIT_WAIT**: wait for `init_done` → CFG_SEND with cfg_idx=0.
  - **CFG_SEND**: load the command at cfg_idx (0x28, 0x06, 0x0C, 0x01), set rs=0, pulse `do_send_data` → CFG_WAIT.
  - **CFG_WAIT**: on `send_data_done`:
    - idx < 3: increment and return to CFG_SEND.
    - idx = 3: go to CLR_DELAY.
  - **CLR_DELAY**: count to CLEAR_WAIT-1 → IDLE.
  - **IDLE**: `ready`=1 unless a refresh is pending. A pending refresh goes to ADDR_SEND with line=0.
  - **ADDR_SEND**: send 0x80 (line 0) or 0xC0 (line 1) with rs=0 → ADDR_WAIT.
  - **ADDR_WAIT**: on done, set col=0 → CHAR_SEND.
  - **CHAR_SEND**: drive `char_addr`={line,col[3:0]}, capture `char_data` into `data_to_send` with rs=1, pulse `do_send_data` → CHAR_WAIT.
  - **CHAR_WAIT**: on done:
    - col < 15: col+1 → CHAR_SEND.
    - col = 15, line 0: line=1 → ADDR_SEND.
    - col = 15, line 1: → IDLE.
- Requests are exactly one cycle wide. A request is only issued in the cycle after the preceding done pulse, or later, so the physical driver is back in IDLE and samples it.
- `refresh` is latched into a pending flag in any state.
  - The flag clears when ADDR_SEND for line 0 is entered.
  - A refresh during a write therefore causes exactly one further full rewrite.
  - Multiple refreshes collapse into one.
  - A refresh before configuration completes is served on entry to IDLE.
- Done pulses arriving in a state not waiting for them are ignored.
- Reset mid-operation returns to PWR_WAIT and repeats the full init. The top level derives the physical driver's active-high reset from the same `reset`, so both restart together.

## Timing
- First `do_init` is high at clock edge POWERON_WAIT after reset deassertion (±1 cycle, fixed by implementation, documented in the bench).
- Request latency: `do_send_data` rises 1 cycle after the done pulse that completes the previous byte.
- `ready` rises 1 cycle after CLR_DELAY expires. It falls the cycle after `refresh` is sampled.
- A full screen is 34 bytes (2 address + 32 characters). Duration is 34 × (physical byte time + 1).
- `char_data` is sampled only in CHAR_SEND. Source changes after that do not affect the byte in flight.

## Structure
- Shared package `lcd_pkg`:
  - state enum.
  - command constants: CMD_FUNC_SET=0x28, CMD_ENTRY=0x06, CMD_DISP_ON=0x0C, CMD_CLEAR=0x01, CMD_LINE0=0x80, CMD_LINE1=0xC0.
  - LCD_COLS=16, LCD_LINES=2.
- No sub-module. The delay counter, configuration index and line/column counters are inline.

## Test plan
- Bench uses POWERON_WAIT=50 and CLEAR_WAIT=20, with a behavioural physical-driver model (done pulse 10 cycles after each request).
- **Power-up**: release reset → `do_init` at cycle ~50; bytes 0x28, 0x06, 0x0C, 0x01 with rs=0 in order; `ready` high ~20 cycles after the final done.
- **Refresh**: formatter returns "A"+index → bytes 0x80, 0x41…0x50, 0xC0, 0x51…0x60; rs=1 only on characters; `ready` returns high.
- **Double refresh**: three `refresh` pulses during a write → exactly one additional 34-byte sequence.
- **Early refresh**: `refresh` during PWR_WAIT → the screen write starts immediately after CLR_DELAY.
- **Reset mid-write**: assert reset after byte 10 → all outputs at reset values asynchronously; full init sequence restarts; no `do_send_data` before `do_init`.
- **Stray done**: `send_data_done` pulse in IDLE → no state change; `ready` stays 1.
